// File: rtl/register_bank_pkg.sv
// Shared defaults for the multi-lane register bank: lane count, depth and width.
package register_bank_pkg;

    localparam int NUM_LANES_DEF = 8;
    localparam int NUM_REGS_DEF  = 64;
    localparam int DATA_W_DEF    = 64;
    localparam int ADDR_W_DEF    = $clog2(NUM_REGS_DEF);

    // Lanes that have dedicated wdata_L / rdata_P_L pins on the top level.
    localparam int PORT_LANES    = 8;

endpackage

// File: rtl/register_lane.sv
// One lane of the register bank: NUM_REGS x DATA_W flops, one write port, two
// enable-gated combinational read ports with no write-through bypass.
module register_lane
    import register_bank_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re0_i,
    input  logic [ADDR_W-1:0] raddr0_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Reset wins over a write sampled on the same edge, so a pending write is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = re0_i ? regs_q[raddr0_i] : '0;
    assign rdata1_o = re1_i ? regs_q[raddr1_i] : '0;

endmodule

// File: rtl/register_bank.sv
// Multi-lane register bank: NUM_LANES independent lanes sharing write/read
// addresses, each with its own write data and two read-data outputs.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEF,
    parameter int NUM_REGS  = NUM_REGS_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LANES-1:0] read_en_0,
    input  logic [NUM_LANES-1:0] read_en_1,
    input  logic [ADDR_W-1:0]    raddr_0,
    input  logic [ADDR_W-1:0]    raddr_1,
    input  logic [NUM_LANES-1:0] write_en,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [DATA_W-1:0]    wdata_0,
    input  logic [DATA_W-1:0]    wdata_1,
    input  logic [DATA_W-1:0]    wdata_2,
    input  logic [DATA_W-1:0]    wdata_3,
    input  logic [DATA_W-1:0]    wdata_4,
    input  logic [DATA_W-1:0]    wdata_5,
    input  logic [DATA_W-1:0]    wdata_6,
    input  logic [DATA_W-1:0]    wdata_7,
    output logic [DATA_W-1:0]    rdata_0_0,
    output logic [DATA_W-1:0]    rdata_0_1,
    output logic [DATA_W-1:0]    rdata_0_2,
    output logic [DATA_W-1:0]    rdata_0_3,
    output logic [DATA_W-1:0]    rdata_0_4,
    output logic [DATA_W-1:0]    rdata_0_5,
    output logic [DATA_W-1:0]    rdata_0_6,
    output logic [DATA_W-1:0]    rdata_0_7,
    output logic [DATA_W-1:0]    rdata_1_0,
    output logic [DATA_W-1:0]    rdata_1_1,
    output logic [DATA_W-1:0]    rdata_1_2,
    output logic [DATA_W-1:0]    rdata_1_3,
    output logic [DATA_W-1:0]    rdata_1_4,
    output logic [DATA_W-1:0]    rdata_1_5,
    output logic [DATA_W-1:0]    rdata_1_6,
    output logic [DATA_W-1:0]    rdata_1_7
);

    logic [DATA_W-1:0] wdata_a [PORT_LANES];
    logic [DATA_W-1:0] rd0_a   [PORT_LANES];
    logic [DATA_W-1:0] rd1_a   [PORT_LANES];

    assign wdata_a[0] = wdata_0;
    assign wdata_a[1] = wdata_1;
    assign wdata_a[2] = wdata_2;
    assign wdata_a[3] = wdata_3;
    assign wdata_a[4] = wdata_4;
    assign wdata_a[5] = wdata_5;
    assign wdata_a[6] = wdata_6;
    assign wdata_a[7] = wdata_7;

    // Pin lanes beyond NUM_LANES have no storage and read back as zero.
    for (genvar l = 0; l < PORT_LANES; l++) begin : g_lane
        if (l < NUM_LANES) begin : g_used
            register_lane #(
                .NUM_REGS (NUM_REGS),
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W)
            ) u_lane (
                .clk_i    (clk),
                .rst_ni   (rst_n),
                .we_i     (write_en[l]),
                .waddr_i  (waddr),
                .wdata_i  (wdata_a[l]),
                .re0_i    (read_en_0[l]),
                .raddr0_i (raddr_0),
                .re1_i    (read_en_1[l]),
                .raddr1_i (raddr_1),
                .rdata0_o (rd0_a[l]),
                .rdata1_o (rd1_a[l])
            );
        end else begin : g_unused
            assign rd0_a[l] = '0;
            assign rd1_a[l] = '0;
        end
    end

    assign rdata_0_0 = rd0_a[0];
    assign rdata_0_1 = rd0_a[1];
    assign rdata_0_2 = rd0_a[2];
    assign rdata_0_3 = rd0_a[3];
    assign rdata_0_4 = rd0_a[4];
    assign rdata_0_5 = rd0_a[5];
    assign rdata_0_6 = rd0_a[6];
    assign rdata_0_7 = rd0_a[7];
    assign rdata_1_0 = rd1_a[0];
    assign rdata_1_1 = rd1_a[1];
    assign rdata_1_2 = rd1_a[2];
    assign rdata_1_3 = rd1_a[3];
    assign rdata_1_4 = rd1_a[4];
    assign rdata_1_5 = rd1_a[5];
    assign rdata_1_6 = rd1_a[6];
    assign rdata_1_7 = rd1_a[7];

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: directed vector table, hand-written reset and
// read-during-write sequences, and a randomized sweep against a lane/address array model.
module tb_register_bank;

    localparam int NL = 8;
    localparam int NR = 64;
    localparam int DW = 64;
    localparam int AW = 6;

    logic          clk;
    logic          rst_n;
    logic [NL-1:0] read_en_0, read_en_1, write_en;
    logic [AW-1:0] raddr_0, raddr_1, waddr;
    logic [DW-1:0] wdata [NL];
    logic [DW-1:0] rdata0 [NL];
    logic [DW-1:0] rdata1 [NL];

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: plain storage indexed by lane and address.
    logic [DW-1:0] model [NL][NR];

    typedef struct {
        logic [NL-1:0] we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wd   [NL];
        logic [NL-1:0] re0;
        logic [AW-1:0] ra0;
        logic [NL-1:0] re1;
        logic [AW-1:0] ra1;
        logic [DW-1:0] exp0 [NL];
        logic [DW-1:0] exp1 [NL];
    } vec_t;

    vec_t vecs [7];

    register_bank dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .read_en_0 (read_en_0),
        .read_en_1 (read_en_1),
        .raddr_0   (raddr_0),
        .raddr_1   (raddr_1),
        .write_en  (write_en),
        .waddr     (waddr),
        .wdata_0   (wdata[0]),
        .wdata_1   (wdata[1]),
        .wdata_2   (wdata[2]),
        .wdata_3   (wdata[3]),
        .wdata_4   (wdata[4]),
        .wdata_5   (wdata[5]),
        .wdata_6   (wdata[6]),
        .wdata_7   (wdata[7]),
        .rdata_0_0 (rdata0[0]),
        .rdata_0_1 (rdata0[1]),
        .rdata_0_2 (rdata0[2]),
        .rdata_0_3 (rdata0[3]),
        .rdata_0_4 (rdata0[4]),
        .rdata_0_5 (rdata0[5]),
        .rdata_0_6 (rdata0[6]),
        .rdata_0_7 (rdata0[7]),
        .rdata_1_0 (rdata1[0]),
        .rdata_1_1 (rdata1[1]),
        .rdata_1_2 (rdata1[2]),
        .rdata_1_3 (rdata1[3]),
        .rdata_1_4 (rdata1[4]),
        .rdata_1_5 (rdata1[5]),
        .rdata_1_6 (rdata1[6]),
        .rdata_1_7 (rdata1[7])
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int lane, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s lane %0d: got %h expected %h", name, lane, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int l = 0; l < NL; l++)
            for (int a = 0; a < NR; a++)
                model[l][a] = '0;
    endtask

    // Driver: present a write at the negedge, commit it at the posedge.
    task automatic do_write(input logic [NL-1:0] we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd [NL]);
        @(negedge clk);
        write_en = we;
        waddr    = addr;
        wdata    = wd;
        @(posedge clk);
        if (rst_n) begin
            for (int l = 0; l < NL; l++)
                if (we[l]) model[l][addr] = wd[l];
        end
        #1;
        write_en = '0;
    endtask

    task automatic set_reads(input logic [NL-1:0] re0, input logic [AW-1:0] ra0,
                             input logic [NL-1:0] re1, input logic [AW-1:0] ra1);
        read_en_0 = re0;
        raddr_0   = ra0;
        read_en_1 = re1;
        raddr_1   = ra1;
        #1;
    endtask

    // Scoreboard: every output against the model and the current read command.
    task automatic check_model(input string name);
        for (int l = 0; l < NL; l++) begin
            check({name, "_p0"}, l, rdata0[l], read_en_0[l] ? model[l][raddr_0] : '0);
            check({name, "_p1"}, l, rdata1[l], read_en_1[l] ? model[l][raddr_1] : '0);
        end
    endtask

    task automatic check_zero(input string name);
        for (int l = 0; l < NL; l++) begin
            check({name, "_p0"}, l, rdata0[l], '0);
            check({name, "_p1"}, l, rdata1[l], '0);
        end
    endtask

    initial begin
        logic [DW-1:0] x [NL];
        logic [DW-1:0] y [NL];
        logic [DW-1:0] z [NL];
        logic [DW-1:0] wd [NL];
        logic [DW-1:0] oldv [NL];

        rst_n     = 1'b1;
        write_en  = '0;
        waddr     = '0;
        read_en_0 = '0;
        read_en_1 = '0;
        raddr_0   = '0;
        raddr_1   = '0;
        for (int l = 0; l < NL; l++) wdata[l] = '0;
        clear_model();

        // Reset: outputs zero with every enable set
        #2 rst_n = 1'b0;
        set_reads('1, '0, '1, '0);
        check_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_reads('1, AW'($urandom_range(0, NR - 1)), '1, AW'($urandom_range(0, NR - 1)));
            check_zero("post_reset");
        end

        // Directed vector table
        for (int l = 0; l < NL; l++) begin
            x[l] = {$urandom, $urandom};
            y[l] = {$urandom, $urandom};
            z[l] = {$urandom, $urandom};
        end
        foreach (vecs[i]) begin
            vecs[i].we = '0; vecs[i].waddr = '0;
            vecs[i].re0 = '0; vecs[i].ra0 = '0; vecs[i].re1 = '0; vecs[i].ra1 = '0;
            for (int l = 0; l < NL; l++) begin
                vecs[i].wd[l] = '0; vecs[i].exp0[l] = '0; vecs[i].exp1[l] = '0;
            end
        end
        // 0: write all lanes at 5, read port 0 only
        vecs[0].we = 8'hFF; vecs[0].waddr = 5; vecs[0].wd = x;
        vecs[0].re0 = 8'hFF; vecs[0].ra0 = 5; vecs[0].ra1 = 5; vecs[0].exp0 = x;
        // 1: port 1 only
        vecs[1].re1 = 8'hFF; vecs[1].ra1 = 5; vecs[1].exp1 = x;
        // 2: both ports at the same address
        vecs[2].re0 = 8'hFF; vecs[2].ra0 = 5; vecs[2].re1 = 8'hFF; vecs[2].ra1 = 5;
        vecs[2].exp0 = x; vecs[2].exp1 = x;
        // 3: lane 0 only; lane 1 data must not land
        vecs[3].we = 8'h01; vecs[3].waddr = 5;
        for (int l = 0; l < NL; l++) vecs[3].wd[l] = 64'hDEAD;
        vecs[3].wd[0] = 64'h1111_2222_3333_4444;
        vecs[3].re0 = 8'hFF; vecs[3].ra0 = 5; vecs[3].re1 = 8'hFF; vecs[3].ra1 = 5;
        vecs[3].exp0 = x; vecs[3].exp1 = x;
        vecs[3].exp0[0] = 64'h1111_2222_3333_4444;
        vecs[3].exp1[0] = 64'h1111_2222_3333_4444;
        // 4: top address, ports at different addresses
        vecs[4].we = 8'hFF; vecs[4].waddr = 63; vecs[4].wd = y;
        vecs[4].re0 = 8'hFF; vecs[4].ra0 = 63; vecs[4].re1 = 8'hFF; vecs[4].ra1 = 5;
        vecs[4].exp0 = y; vecs[4].exp1 = x;
        vecs[4].exp1[0] = 64'h1111_2222_3333_4444;
        // 5: partial read enables
        vecs[5].re0 = 8'hAA; vecs[5].ra0 = 63; vecs[5].re1 = 8'h55; vecs[5].ra1 = 5;
        for (int l = 0; l < NL; l++) begin
            vecs[5].exp0[l] = (l % 2 == 1) ? y[l] : '0;
            vecs[5].exp1[l] = (l % 2 == 0) ? x[l] : '0;
        end
        vecs[5].exp1[0] = 64'h1111_2222_3333_4444;
        // 6: address 0
        vecs[6].we = 8'hFF; vecs[6].waddr = 0; vecs[6].wd = z;
        vecs[6].re0 = 8'hFF; vecs[6].ra0 = 0; vecs[6].re1 = 8'hFF; vecs[6].ra1 = 63;
        vecs[6].exp0 = z; vecs[6].exp1 = y;

        foreach (vecs[i]) begin
            do_write(vecs[i].we, vecs[i].waddr, vecs[i].wd);
            set_reads(vecs[i].re0, vecs[i].ra0, vecs[i].re1, vecs[i].ra1);
            for (int l = 0; l < NL; l++) begin
                check($sformatf("vec%0d_p0", i), l, rdata0[l], vecs[i].exp0[l]);
                check($sformatf("vec%0d_p1", i), l, rdata1[l], vecs[i].exp1[l]);
            end
        end

        // Read during write: old value before the edge, new value after
        @(negedge clk);
        for (int l = 0; l < NL; l++) begin
            oldv[l] = model[l][7];
            wd[l]   = {$urandom, $urandom};
        end
        write_en = 8'hFF; waddr = 7; wdata = wd;
        set_reads(8'hFF, 7, 8'hFF, 7);
        for (int l = 0; l < NL; l++) begin
            check("rdw_before_p0", l, rdata0[l], oldv[l]);
            check("rdw_before_p1", l, rdata1[l], oldv[l]);
        end
        @(posedge clk);
        #1;
        write_en = '0;
        for (int l = 0; l < NL; l++) begin
            model[l][7] = wd[l];
            check("rdw_after_p0", l, rdata0[l], wd[l]);
            check("rdw_after_p1", l, rdata1[l], wd[l]);
        end

        // Randomized sweep: every address, 100 writes each, three read patterns
        for (int a = 0; a < NR; a++) begin
            for (int k = 0; k < 100; k++) begin
                logic [NL-1:0] we;
                for (int l = 0; l < NL; l++) wd[l] = {$urandom, $urandom};
                we = ($urandom_range(0, 3) == 0) ? NL'($urandom_range(0, 255)) : 8'hFF;
                do_write(we, AW'(a), wd);
                set_reads(8'hFF, AW'(a), 8'h00, AW'($urandom_range(0, NR - 1)));
                check_model("rnd_port0");
                set_reads(8'h00, AW'($urandom_range(0, NR - 1)), 8'hFF, AW'(a));
                check_model("rnd_port1");
                set_reads(NL'($urandom), AW'(a), NL'($urandom), AW'($urandom_range(0, NR - 1)));
                check_model("rnd_dual");
            end
        end

        // Reset between edges clears immediately
        for (int l = 0; l < NL; l++) wd[l] = 64'hA5A5;
        do_write(8'hFF, 3, wd);
        set_reads(8'hFF, 3, 8'hFF, 3);
        check_model("pre_reset_reg3");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        check_zero("async_reset_reg3");

        // A write presented while reset is held must be dropped
        write_en = 8'hFF; waddr = 3;
        for (int l = 0; l < NL; l++) wdata[l] = 64'hDEAD_BEEF;
        @(posedge clk);
        #1;
        write_en = '0;
        @(negedge clk);
        rst_n = 1'b1;
        set_reads(8'hFF, 3, 8'hFF, 3);
        check_zero("write_in_reset");
        set_reads(8'hFF, 5, 8'hFF, 63);
        check_zero("reset_all_regs");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
